stream_demux_1ton: RTL and testbench
====================================

# stream_demux_1ton

Registered, packet-aware 1-to-N stream demultiplexer with valid/ready handshakes. It routes each packet from a single input stream to one of NUM_CH output channels, using the select captured on the packet's first beat. Packets addressed to a non-existent channel are discarded and counted. Deselected channels drive zero data. The block sits between a single upstream packet source and per-channel consumers.

## Interface
- DATA_W, default 8: payload width in bits
- NUM_CH, default 4: number of output channels, from 2 to 2**SEL_W
- SEL_W, default 2: select width

- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid && in_ready
- in_data  in  DATA_W  input payload
- in_sel  in  SEL_W  destination channel; sampled only on the first beat of a packet
- in_last  in  1  final beat of packet
- out_valid  out  NUM_CH  per-channel valid
- out_ready  in  NUM_CH  per-channel ready
- out_data  out  NUM_CH*DATA_W  per-channel payload; channel c occupies bits [c*DATA_W +: DATA_W]
- out_last  out  NUM_CH  per-channel last
- drop_cnt  out  16  count of dropped packets; saturating
- busy  out  1  high when a packet is open or a beat is held

## Operation
- Storage is a single output holding register: reg_valid, reg_ch, reg_data, reg_last.
- The FSM has three states:
  - IDLE: no packet open.
  - PKT: a packet is open to cur_sel.
  - DROP: an invalid-destination packet is being discarded.
- in_ready rules:
  - In DROP, in_ready = 1.
  - Otherwise, in_ready = !reg_valid || out_ready[reg_ch].
  - in_ready never depends on in_sel or in_valid.
  - in_ready = 0 while rst_n is low.
- Accepted beat in IDLE, with in_sel < NUM_CH:
  - Load the holding register with reg_ch = in_sel.
  - Latch cur_sel = in_sel.
  - Next state is PKT if !in_last, otherwise stay in IDLE.
- Accepted beat in IDLE, with in_sel >= NUM_CH:
  - The beat is not loaded.
  - drop_cnt increments by 1, saturating at 16'hFFFF.
  - Next state is DROP if !in_last, otherwise stay in IDLE.
- Accepted beat in PKT:
  - Load the holding register with reg_ch = cur_sel; in_sel is ignored.
  - in_last returns the FSM to IDLE.
- Accepted beat in DROP:
  - The beat is discarded.
  - in_last returns the FSM to IDLE.
  - drop_cnt does not change.
- Register drain:
  - The register empties when out_ready[reg_ch] is high while reg_valid is high.
  - A simultaneous drain and load is legal and keeps reg_valid = 1.
- Output drive:
  - out_valid[c] = reg_valid && reg_ch == c.
  - out_data slice c = reg_data if out_valid[c], else 0.
  - out_last[c] = reg_last && out_valid[c].
- busy = (state != IDLE) || reg_valid.
- When NUM_CH < 2**SEL_W, select values from NUM_CH up to 2**SEL_W-1 are the drop addresses. When NUM_CH == 2**SEL_W, nothing is ever dropped.

## Timing
- Reset (rst_n low, asynchronous) forces:
  - state = IDLE, reg_valid = 0, cur_sel = 0, drop_cnt = 0.
  - All out_valid, out_data, out_last = 0; busy = 0; in_ready = 0.
- Reset asserted mid-packet abandons the packet. After release, the next accepted beat is treated as a first beat.
- Latency: a beat accepted at edge k appears on its channel's outputs in the cycle after edge k.
- Throughput: 1 beat/cycle sustained while the destination's out_ready stays high. This holds across channel switches between packets, with no bubble.
- Back-pressure: while reg_valid && !out_ready[reg_ch], in_ready = 0 (except in DROP), and the outputs hold stable.
- Readiness of other channels has no effect.
- A single-beat packet (in_last on its first beat) leaves the state in IDLE.
- A change in in_sel mid-packet has no effect.

## Test plan
- Reset with in_valid = 1 → in_ready = 0 and all outputs 0. After release, in_ready = 1 and drop_cnt = 0.
- Channel sweep:
  - Stimulus: send four single-beat packets, sel = 0,1,2,3, data 8'hA0..8'hA3, all out_ready = 1.
  - Required: out_valid = 4'b0001, 4'b0010, 4'b0100, 4'b1000 on consecutive cycles, each delayed 1 cycle from acceptance. The selected slice carries the data; all other slices read 0.
- Packet lock:
  - Stimulus: 3-beat packet with sel = 2 on beat 1 and sel = 0 on beats 2 and 3.
  - Required: all 3 beats exit channel 2, out_last[2] is high on beat 3, and busy drops the cycle after the last drain.
- Back-pressure:
  - Stimulus: out_ready[1] = 0 for 5 cycles during a packet to channel 1.
  - Required: in_ready = 0 and out_data slice 1 is stable for those cycles. No beat is lost or duplicated after ready returns.
- Drop (NUM_CH = 3, SEL_W = 2):
  - Stimulus: 4-beat packet with sel = 3, then a 1-beat packet with sel = 3.
  - Required: in_ready = 1 throughout the first packet, no out_valid, drop_cnt = 2.
- Saturation and mid-packet reset:
  - Stimulus: force 65 537 dropped packets.
  - Required: drop_cnt = 16'hFFFF.
  - Stimulus: assert rst_n low during beat 2 of a packet.
  - Required: all outputs clear immediately, and the next packet routes by its own in_sel.

Source files
------------

// File: rtl/stream_demux_1ton_if.sv
// ---------------------------------------------------------------------------
// stream_demux_1ton_if
// Bundles the single input stream and the NUM_CH output channels of the
// 1-to-N packet demultiplexer.
//   in_valid / in_ready / in_data / in_sel / in_last : upstream packet stream
//   out_valid / out_ready / out_data / out_last       : per-channel streams,
//                                                       channel c data at
//                                                       out_data[c*DATA_W +: DATA_W]
// Modports:
//   slave  : the demultiplexer's view (consumes the input stream, drives
//            the channel outputs)
//   master : the environment's view (source and per-channel sinks)
// ---------------------------------------------------------------------------
interface stream_demux_1ton_if #(
   parameter int DATA_W = 8,
   parameter int NUM_CH = 4,
   parameter int SEL_W  = 2
);
   logic                     in_valid;
   logic                     in_ready;
   logic [DATA_W-1:0]        in_data;
   logic [SEL_W-1:0]         in_sel;
   logic                     in_last;
   logic [NUM_CH-1:0]        out_valid;
   logic [NUM_CH-1:0]        out_ready;
   logic [NUM_CH*DATA_W-1:0] out_data;
   logic [NUM_CH-1:0]        out_last;

   modport slave (
      input  in_valid, in_data, in_sel, in_last, out_ready,
      output in_ready, out_valid, out_data, out_last
   );

   modport master (
      output in_valid, in_data, in_sel, in_last, out_ready,
      input  in_ready, out_valid, out_data, out_last
   );
endinterface

// File: rtl/stream_demux_1ton.sv
// ---------------------------------------------------------------------------
// stream_demux_1ton
// Registered, packet-aware 1-to-N stream demultiplexer. The destination is
// taken from in_sel on the first beat of each packet and held for the rest
// of the packet. Packets addressed to a channel index >= NUM_CH are
// swallowed and counted in a saturating 16-bit counter.
// Ports:
//   clk      : clock, all state changes on the rising edge
//   rst_n    : asynchronous active-low reset
//   bus      : stream_demux_1ton_if.slave, input stream + channel outputs
//   drop_cnt : number of dropped packets, saturates at 16'hFFFF
//   busy     : a packet is open or a beat sits in the holding register
// ---------------------------------------------------------------------------
module stream_demux_1ton #(
   parameter int DATA_W = 8,
   parameter int NUM_CH = 4,
   parameter int SEL_W  = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   stream_demux_1ton_if.slave   bus,
   output logic [15:0]          drop_cnt,
   output logic                 busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PKT  = 2'd1,
      DROP = 2'd2
   } state_t;

   state_t              state;
   logic                reg_valid;
   logic [SEL_W-1:0]    reg_ch;
   logic [DATA_W-1:0]   reg_data;
   logic                reg_last;
   logic [SEL_W-1:0]    cur_sel;

   logic                sel_bad;
   logic                accept;
   logic                load;
   logic                drain;
   logic                in_ready_w;

   logic [NUM_CH-1:0]        out_valid_w;
   logic [NUM_CH-1:0]        out_last_w;
   logic [NUM_CH*DATA_W-1:0] out_data_w;

   // Drop addresses only exist when the select space is larger than the
   // channel count; otherwise the comparison is folded away entirely.
   generate
      if (NUM_CH < (1 << SEL_W)) begin : g_drop
         assign sel_bad = (bus.in_sel >= SEL_W'(NUM_CH));
      end else begin : g_nodrop
         assign sel_bad = 1'b0;
      end
   endgenerate

   assign drain = reg_valid && bus.out_ready[reg_ch];

   // Ready looks only at the held beat's own channel, so a drain and a new
   // load can share one edge and back-to-back packets see no bubble. A
   // discarded packet is never held, so DROP accepts unconditionally.
   assign in_ready_w = rst_n && ((state == DROP) || !reg_valid || bus.out_ready[reg_ch]);
   assign bus.in_ready = in_ready_w;

   assign accept = bus.in_valid && in_ready_w;
   assign load   = accept && ((state == PKT) || ((state == IDLE) && !sel_bad));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         reg_valid <= 1'b0;
         reg_ch    <= '0;
         reg_data  <= '0;
         reg_last  <= 1'b0;
         cur_sel   <= '0;
         drop_cnt  <= 16'd0;
      end else begin
         if (load) begin
            reg_valid <= 1'b1;
            reg_data  <= bus.in_data;
            reg_last  <= bus.in_last;
            reg_ch    <= (state == PKT) ? cur_sel : bus.in_sel;
         end else if (drain) begin
            reg_valid <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (accept) begin
                  if (sel_bad) begin
                     if (drop_cnt != 16'hFFFF) begin
                        drop_cnt <= drop_cnt + 16'd1;
                     end
                     if (!bus.in_last) begin
                        state <= DROP;
                     end
                  end else begin
                     cur_sel <= bus.in_sel;
                     if (!bus.in_last) begin
                        state <= PKT;
                     end
                  end
               end
            end
            PKT, DROP: begin
               if (accept && bus.in_last) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Only the held beat's channel sees data; every other slice reads zero.
   generate
      for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_out
         assign out_valid_w[gi] = reg_valid && (reg_ch == SEL_W'(gi));
         assign out_last_w[gi]  = reg_last && out_valid_w[gi];
         assign out_data_w[gi*DATA_W +: DATA_W] = out_valid_w[gi] ? reg_data : '0;
      end
   endgenerate

   assign bus.out_valid = out_valid_w;
   assign bus.out_last  = out_last_w;
   assign bus.out_data  = out_data_w;

   assign busy = (state != IDLE) || reg_valid;

endmodule

// File: tb/tb_stream_demux_1ton.sv
// ---------------------------------------------------------------------------
// tb_stream_demux_1ton
// Bench for stream_demux_1ton with NUM_CH = 3, SEL_W = 2 so that select
// value 3 is a drop address. Accepted beats are routed by a packet-level
// reference model into per-channel expected queues; a monitor pops and
// compares whenever a channel completes a handshake.
// ---------------------------------------------------------------------------
module tb_stream_demux_1ton;
   localparam int DW  = 8;
   localparam int NCH = 3;
   localparam int SW  = 2;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b1;
   logic [15:0] drop_cnt;
   logic        busy;

   always #5 clk = ~clk;

   stream_demux_1ton_if #(.DATA_W(DW), .NUM_CH(NCH), .SEL_W(SW)) bus ();

   stream_demux_1ton #(.DATA_W(DW), .NUM_CH(NCH), .SEL_W(SW)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus),
      .drop_cnt (drop_cnt),
      .busy     (busy)
   );

   int vecs = 0;
   int errs = 0;

   // Reference model: packet open flag, locked destination (-1 = discard),
   // saturating drop count, and per-channel expected {data, last}.
   logic [DW:0] exp_q [NCH][$];
   bit          m_open  = 0;
   int          m_dest  = 0;
   int          m_drops = 0;
   bit          rand_rdy = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_accept();
      if (!m_open) begin
         if (int'(bus.in_sel) >= NCH) begin
            m_dest = -1;
            if (m_drops < 16'hFFFF) m_drops++;
         end else begin
            m_dest = int'(bus.in_sel);
         end
         m_open = !bus.in_last;
      end else if (bus.in_last) begin
         m_open = 0;
      end
      if (m_dest >= 0) exp_q[m_dest].push_back({bus.in_data, bus.in_last});
   endtask

   task automatic model_flush();
      for (int c = 0; c < NCH; c++) exp_q[c].delete();
      m_open  = 0;
      m_dest  = 0;
      m_drops = 0;
   endtask

   // Monitor: sampled on the falling edge, mid-cycle.
   always @(negedge clk) begin
      if (rst_n) begin
         chk("onehot", ($countones(bus.out_valid) <= 1), 1);
         for (int c = 0; c < NCH; c++) begin
            logic [DW-1:0] d;
            logic [DW:0]   e;
            d = bus.out_data[c*DW +: DW];
            if (bus.out_valid[c]) begin
               if (bus.out_ready[c]) begin
                  if (exp_q[c].size() == 0) begin
                     vecs++;
                     errs++;
                     $display("FAIL ch%0d_unexpected: got data %0h last %0b, required no beat", c, d, bus.out_last[c]);
                  end else begin
                     e = exp_q[c].pop_front();
                     chk($sformatf("ch%0d_beat", c), {d, bus.out_last[c]}, e);
                  end
               end
            end else begin
               chk($sformatf("ch%0d_idle_zero", c), {d, bus.out_last[c]}, 0);
            end
         end
         if (bus.in_valid && bus.in_ready) model_accept();
      end
   end

   // Random per-channel back-pressure, ready high about 3/4 of the time.
   always @(posedge clk) begin
      if (rand_rdy) begin
         #1;
         for (int c = 0; c < NCH; c++) bus.out_ready[c] = ($urandom_range(0, 3) != 0);
      end
   end

   // Presents one beat from posedge+1 until accepted; returns at posedge+1
   // after the accepting edge with in_valid low. waited = stall cycles.
   task automatic send_beat(input logic [DW-1:0] d, input logic [SW-1:0] s,
                            input logic l, output int waited);
      int t = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_sel   = s;
      bus.in_last  = l;
      @(negedge clk);
      while (!bus.in_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (t >= 200) begin
         vecs++;
         errs++;
         $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles, required acceptance", t);
      end
      waited = t;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int t = 0;
      int qs = 0;
      @(negedge clk);
      while (busy && t < 500) begin
         @(negedge clk);
         t++;
      end
      chk("idle_timeout", (t >= 500), 0);
      for (int c = 0; c < NCH; c++) qs += exp_q[c].size();
      chk("queues_empty", qs, 0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int w;
      logic [2:0] sweep_exp [4];
      sweep_exp[0] = 3'b001;
      sweep_exp[1] = 3'b010;
      sweep_exp[2] = 3'b100;
      sweep_exp[3] = 3'b000;

      bus.in_valid  = 1'b1;
      bus.in_data   = 8'h5A;
      bus.in_sel    = '0;
      bus.in_last   = 1'b0;
      bus.out_ready = '1;

      // ---- reset with in_valid high ----
      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_in_ready", bus.in_ready, 0);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_data", bus.out_data, 0);
      chk("rst_out_last", bus.out_last, 0);
      chk("rst_busy", busy, 0);
      chk("rst_drop_cnt", drop_cnt, 0);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      rst_n = 1'b1;
      #1;
      chk("post_rst_in_ready", bus.in_ready, 1);
      chk("post_rst_drop_cnt", drop_cnt, 0);
      @(posedge clk);
      #1;

      // ---- channel sweep: one-cycle latency, one beat per cycle ----
      fork
         begin
            for (int i = 0; i < 4; i++) send_beat(8'hA0 + 8'(i), 2'(i), 1'b1, w);
         end
         begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
               logic [DW-1:0] sl;
               @(negedge clk);
               chk($sformatf("sweep_valid%0d", i), bus.out_valid, sweep_exp[i]);
               if (i < NCH) begin
                  sl = bus.out_data[i*DW +: DW];
                  chk($sformatf("sweep_data%0d", i), sl, 8'hA0 + 8'(i));
               end
            end
         end
      join
      wait_idle();

      // ---- packet lock: later in_sel values are ignored ----
      send_beat(8'h11, 2'd2, 1'b0, w);
      send_beat(8'h22, 2'd0, 1'b0, w);
      send_beat(8'h33, 2'd0, 1'b1, w);
      @(negedge clk);
      chk("lock_valid", bus.out_valid, 3'b100);
      chk("lock_last", bus.out_last, 3'b100);
      chk("lock_busy_hold", busy, 1);
      @(negedge clk);
      chk("lock_busy_drop", busy, 0);
      @(posedge clk);
      #1;

      // ---- back-pressure on channel 1 for 5 cycles ----
      bus.out_ready = 3'b101;
      fork
         begin
            for (int i = 0; i < 4; i++) send_beat(8'hC0 + 8'(i), 2'd1, (i == 3), w);
         end
         begin
            int t = 0;
            logic [DW-1:0] snap;
            @(negedge clk);
            while (!bus.out_valid[1] && t < 50) begin
               @(negedge clk);
               t++;
            end
            chk("bp_seen", (t < 50), 1);
            snap = bus.out_data[DW +: DW];
            chk("bp_first_data", snap, 8'hC0);
            for (int i = 0; i < 5; i++) begin
               chk("bp_in_ready", bus.in_ready, 0);
               chk("bp_stable", bus.out_data[DW +: DW], snap);
               chk("bp_valid", bus.out_valid[1], 1);
               if (i < 4) @(negedge clk);
            end
            @(posedge clk);
            #1;
            bus.out_ready = 3'b111;
         end
      join
      wait_idle();

      // ---- drop: accepted without stalls even with every channel stalled ----
      bus.out_ready = 3'b000;
      for (int i = 0; i < 4; i++) begin
         send_beat(8'hD0 + 8'(i), (i == 0) ? 2'd3 : 2'($urandom_range(0, 3)), (i == 3), w);
         chk("drop_ready", w, 0);
         chk("drop_no_valid", bus.out_valid, 0);
      end
      send_beat(8'hDF, 2'd3, 1'b1, w);
      chk("drop_ready_single", w, 0);
      @(negedge clk);
      @(negedge clk);
      // one drop from the sweep's select-3 beat plus the two here
      chk("drop_cnt_3", drop_cnt, 3);
      chk("drop_cnt_model", drop_cnt, m_drops);
      @(posedge clk);
      #1;
      bus.out_ready = 3'b111;

      // ---- randomized traffic with random back-pressure ----
      rand_rdy = 1;
      for (int p = 0; p < 300; p++) begin
         int len;
         logic [SW-1:0] s;
         len = $urandom_range(1, 4);
         s   = 2'($urandom_range(0, 3));
         for (int b = 0; b < len; b++) begin
            send_beat(8'($urandom), (b == 0) ? s : 2'($urandom), (b == len - 1), w);
            if ($urandom_range(0, 3) == 0) begin
               @(posedge clk);
               #1;
            end
         end
      end
      rand_rdy = 0;
      repeat (2) @(posedge clk);
      #1;
      bus.out_ready = 3'b111;
      wait_idle();
      chk("rand_drop_cnt", drop_cnt, m_drops);

      // ---- saturation ----
      for (int i = 0; i < 65537; i++) send_beat(8'(i), 2'd3, 1'b1, w);
      @(negedge clk);
      @(negedge clk);
      chk("drop_cnt_sat", drop_cnt, 16'hFFFF);
      @(posedge clk);
      #1;

      // ---- reset during beat 2 of a packet ----
      send_beat(8'h55, 2'd1, 1'b0, w);
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h66;
      bus.in_sel   = 2'd1;
      bus.in_last  = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", bus.out_valid, 0);
      chk("mid_rst_out_data", bus.out_data, 0);
      chk("mid_rst_out_last", bus.out_last, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_in_ready", bus.in_ready, 0);
      chk("mid_rst_drop_cnt", drop_cnt, 0);
      model_flush();
      bus.in_valid = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      chk("mid_rst_release_ready", bus.in_ready, 1);
      @(posedge clk);
      #1;
      send_beat(8'h77, 2'd2, 1'b1, w);
      chk("after_rst_route", bus.out_valid, 3'b100);
      chk("after_rst_data", bus.out_data[2*DW +: DW], 8'h77);
      wait_idle();

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
